pcre_id_collector: RTL and testbench
====================================

Name: pcre_id_collector

Overview:
- Sits directly downstream of the PCRE priority-serializer chain; consumes the 10-bit matched-rule ID stream (0 = no match) plus packet-end marker.
- Buffers IDs per packet in a FIFO and appends a per-packet trailer carrying the match count and a drop flag.
- Presents records to the alert/report stage over a valid/ready interface.
- Drives the permission input at the head of the serializer chain, so IDs are throttled rather than lost.

Parameters:
ID_W, 10, width of rule ID and trailer count field
DEPTH, 16, FIFO entries (power of two, >= 4)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_in  in  ID_W  matched rule ID from serializer chain; 0 = no match this cycle
eop_in  in  1  end of packet, same timing as serializer eop input
perm_out  out  1  grant to head of serializer chain (its r_permission)
out_valid  out  1  FIFO head holds a record
out_ready  in  1  downstream accepts record
out_data  out  ID_W  rule ID, or match count when out_last=1
out_last  out  1  record is the packet trailer
out_drop  out  1  trailer only: at least one ID/event lost for this packet
err_trailer_lost  out  1  sticky: a trailer was discarded because the FIFO was full

Behaviour:
- Reset (sync, active-high, overrides everything in that cycle):
  - FIFO empty; out_valid=0, out_data=0, out_last=0, out_drop=0.
  - perm_out=1; err_trailer_lost=0; pkt_count=0; pkt_drop=0; eop_d=0.
  - Reset mid-packet discards all buffered records and the partial packet state.
- FIFO entry = {last, drop, data}. First-word-fall-through:
  - out_* reflect the head entry combinationally from storage.
  - out_valid = !empty.
  - Pop when out_valid && out_ready.
- Occupancy counter 0..DEPTH; free = DEPTH - occupancy.
  - Simultaneous push and pop leave occupancy unchanged.
  - Pop when empty is ignored.
- perm_out = (free >= 3), decoded from registered occupancy.
  - Reserves one slot for the ID already in flight (the serializer emits one cycle after permission) and one for the trailer.
- ID path, when eop_d=0 and id_in != 0:
  - free >= 2: push {0,0,id_in}; pkt_count += 1, saturating at 2^ID_W-1.
  - Otherwise drop the ID; pkt_drop=1.
  - Free is evaluated before this cycle's pop.
- Trailer path: eop_in is registered into eop_d. In the cycle eop_d=1:
  - Push trailer {1, pkt_drop, pkt_count}, then clear pkt_count=0 and pkt_drop=0.
  - A packet with no matches still produces a trailer with count 0.
  - If free = 0 (pop in the same cycle does not count), discard the trailer, set err_trailer_lost (cleared only by reset), and still clear the packet state.
- Nonzero id_in while eop_d=1: upstream guarantees ID=0 in this cycle. If it is violated, the ID is dropped and the trailer is pushed with drop=1.
- An ID arriving in the same cycle as eop_in (eop_d=0) belongs to the ending packet and is pushed normally before its trailer.
- At most one push per cycle. Pointers wrap modulo DEPTH.
- Latency: id_in sampled at edge N is visible on out_* after edge N when the FIFO was empty. The trailer is visible one cycle after the eop_in edge.

Test Plan:
- Reset, then IDs 3,7,12 on consecutive cycles, eop_in on the cycle after 12, out_ready=1:
  - out sequence is (3,last0), (7,last0), (12,last0), (3,last1,drop0).
- eop_in with no prior IDs:
  - a single trailer (0,last1,drop0) one cycle later.
- out_ready=0, IDs 1..20 streamed while perm_out is obeyed:
  - perm_out drops when occupancy reaches 14.
  - No ID is lost; all IDs plus the trailer appear in order once out_ready=1.
- Ignore perm_out, 20 IDs with out_ready=0, then eop:
  - 15 IDs stored.
  - Trailer reads count=15, drop=1.
  - err_trailer_lost stays 0.
- FIFO full of trailers (16 back-to-back eops, out_ready=0), then one more eop:
  - err_trailer_lost=1.
  - The 17th trailer is absent after draining.
  - The next packet's trailer is correct.
- Assert reset while 5 records are buffered:
  - Next cycle out_valid=0 and perm_out=1.
  - The following packet yields a fresh trailer with count from 0.

Source files
------------

// File: rtl/pcre_id_collector_if.sv
// pcre_id_collector_if
//   Bundles the serializer-side inputs (id_in, eop_in, perm_out) and the
//   report-side record stream (out_*) of the PCRE ID collector.
//   master : the environment (drives IDs/eop and out_ready)
//   slave  : the collector (drives permission, records and error flag)
interface pcre_id_collector_if #(
    parameter int ID_W = 10
);
    logic [ID_W-1:0] id_in;
    logic            eop_in;
    logic            perm_out;
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_data;
    logic            out_last;
    logic            out_drop;
    logic            err_trailer_lost;

    modport master (
        output id_in, eop_in, out_ready,
        input  perm_out, out_valid, out_data, out_last, out_drop, err_trailer_lost
    );

    modport slave (
        input  id_in, eop_in, out_ready,
        output perm_out, out_valid, out_data, out_last, out_drop, err_trailer_lost
    );
endinterface

// File: rtl/pcre_id_collector.sv
// pcre_id_collector
//   Collects matched rule IDs from the serializer chain into a FIFO and
//   closes each packet with a trailer record {last=1, drop, match count}.
//   Records are presented first-word-fall-through on a valid/ready port.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : slave side of pcre_id_collector_if
//            id_in/eop_in   - ID stream (0 = no match) and end-of-packet
//            perm_out       - permission to the head of the serializer chain
//            out_valid/out_ready/out_data/out_last/out_drop - record stream
//            err_trailer_lost - sticky, a trailer was discarded (FIFO full)
module pcre_id_collector #(
    parameter int ID_W   = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic                clk,
    input logic                reset,
    pcre_id_collector_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] FREE_1  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] FREE_2  = (ADDR_W + 1)'(2);
    localparam logic [ADDR_W:0] FREE_3  = (ADDR_W + 1)'(3);

    // entry = {last, drop, data}
    logic [ID_W+1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   occ;
    logic [ADDR_W:0]   free_slots;
    logic [ID_W-1:0]   pkt_count;
    logic              pkt_drop;
    logic              eop_d;
    logic              err_q;

    logic              empty;
    logic              pop;
    logic              push;
    logic [ID_W+1:0]   push_data;
    logic              id_hit;

    assign free_slots = DEPTH_C - occ;
    assign empty      = (occ == '0);
    assign pop        = !empty && bus.out_ready;
    assign id_hit     = (bus.id_in != '0);

    // Only one push per cycle: the trailer cycle owns the write port, and an
    // ID seen then (protocol violation) is dropped and flagged in the trailer.
    // IDs need two free slots so the trailer always has room behind them.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (eop_d) begin
            if (free_slots >= FREE_1) begin
                push      = 1'b1;
                push_data = {1'b1, pkt_drop | id_hit, pkt_count};
            end
        end else if (id_hit && (free_slots >= FREE_2)) begin
            push      = 1'b1;
            push_data = {2'b00, bus.id_in};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            pkt_count <= '0;
            pkt_drop  <= 1'b0;
            eop_d     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            eop_d <= bus.eop_in;

            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + FREE_1;
                2'b01:   occ <= occ - FREE_1;
                default: occ <= occ;
            endcase

            if (eop_d) begin
                pkt_count <= '0;
                pkt_drop  <= 1'b0;
                if (free_slots == '0) begin
                    err_q <= 1'b1;
                end
            end else if (id_hit) begin
                if (free_slots >= FREE_2) begin
                    if (pkt_count != {ID_W{1'b1}}) begin
                        pkt_count <= pkt_count + ID_W'(1);
                    end
                end else begin
                    pkt_drop <= 1'b1;
                end
            end
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign bus.out_valid = !empty;
    assign {bus.out_last, bus.out_drop, bus.out_data} = empty ? '0 : mem[rd_ptr];

    // One slot for the ID already in flight behind the grant, one for the trailer.
    assign bus.perm_out         = (free_slots >= FREE_3);
    assign bus.err_trailer_lost = err_q;
endmodule

// File: tb/tb_pcre_id_collector.sv
module tb_pcre_id_collector;
    localparam int ID_W = 10;

    logic clk;
    logic reset;

    pcre_id_collector_if #(.ID_W(ID_W)) bus ();

    pcre_id_collector #(
        .ID_W   (ID_W),
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // record = {last, drop, data}
    logic [ID_W+1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ID_W+1:0] rec(input logic last, input logic drop, input int data);
        logic [ID_W-1:0] d;
        d = ID_W'(data);
        return {last, drop, d};
    endfunction

    // Scoreboard: compare every accepted record against the expected queue.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_record", 32'({bus.out_last, bus.out_drop, bus.out_data}), 32'hFFFF_FFFF);
            end else begin
                check_eq("record", 32'({bus.out_last, bus.out_drop, bus.out_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input int id, input logic eop);
        bus.id_in  = ID_W'(id);
        bus.eop_in = eop;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int cyc;
        bus.id_in     = '0;
        bus.eop_in    = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        step(0, 1'b0);
        check_eq({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int  sent;
        int  id;
        logic perm_prev;

        bus.id_in     = '0;
        bus.eop_in    = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_last", 32'(bus.out_last), 32'd0);
        check_eq("rst_drop", 32'(bus.out_drop), 32'd0);
        check_eq("rst_perm", 32'(bus.perm_out), 32'd1);
        check_eq("rst_err", 32'(bus.err_trailer_lost), 32'd0);

        // basic packet: 3,7,12 then trailer count 3
        bus.out_ready = 1'b1;
        exp_q.push_back(rec(0, 0, 3));
        step(3, 1'b0);
        check_eq("lat_valid", 32'(bus.out_valid), 32'd1);
        check_eq("lat_data", 32'(bus.out_data), 32'd3);
        exp_q.push_back(rec(0, 0, 7));
        step(7, 1'b0);
        exp_q.push_back(rec(0, 0, 12));
        step(12, 1'b0);
        exp_q.push_back(rec(1, 0, 3));
        step(0, 1'b1);
        step(0, 1'b0);
        check_eq("trl_head_last", 32'(bus.out_last), 32'd1);
        check_eq("trl_head_cnt", 32'(bus.out_data), 32'd3);
        drain("pkt1");

        // empty packet: trailer only, one cycle after the eop edge
        bus.out_ready = 1'b0;
        exp_q.push_back(rec(1, 0, 0));
        step(0, 1'b1);
        check_eq("empty_pkt_not_yet", 32'(bus.out_valid), 32'd0);
        step(0, 1'b0);
        check_eq("empty_pkt_valid", 32'(bus.out_valid), 32'd1);
        check_eq("empty_pkt_rec", 32'({bus.out_last, bus.out_drop, bus.out_data}), 32'(rec(1, 0, 0)));
        drain("empty_pkt");

        // stream 1..20 obeying perm_out (one-cycle grant latency)
        bus.out_ready = 1'b0;
        sent      = 0;
        perm_prev = bus.perm_out;
        for (int cyc = 0; cyc < 300 && sent < 20; cyc++) begin
            if (cyc == 40) bus.out_ready = 1'b1;
            id = perm_prev ? sent + 1 : 0;
            if (id != 0) exp_q.push_back(rec(0, 0, id));
            step(id, 1'b0);
            if (id != 0) begin
                sent++;
                if (sent == 13) check_eq("perm_at_13", 32'(bus.perm_out), 32'd1);
                if (sent == 14) check_eq("perm_at_14", 32'(bus.perm_out), 32'd0);
            end
            perm_prev = bus.perm_out;
        end
        check_eq("stream_sent", 32'(sent), 32'd20);
        exp_q.push_back(rec(1, 0, 20));
        step(0, 1'b1);
        drain("stream");

        // ignore perm_out: 20 IDs, 15 fit, trailer flags the drops
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i <= 15) exp_q.push_back(rec(0, 0, i));
            step(i, 1'b0);
        end
        exp_q.push_back(rec(1, 1, 15));
        step(0, 1'b1);
        step(0, 1'b0);
        check_eq("ovf_err", 32'(bus.err_trailer_lost), 32'd0);
        check_eq("ovf_perm", 32'(bus.perm_out), 32'd0);
        drain("ovf");
        check_eq("ovf_err_after", 32'(bus.err_trailer_lost), 32'd0);

        // 17 back-to-back eops into a stalled FIFO: last trailer is lost
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(rec(1, 0, 0));
        for (int i = 0; i < 17; i++) step(0, 1'b1);
        check_eq("full_err_pre", 32'(bus.err_trailer_lost), 32'd0);
        step(0, 1'b0);
        check_eq("full_err", 32'(bus.err_trailer_lost), 32'd1);
        drain("full");
        check_eq("full_err_sticky", 32'(bus.err_trailer_lost), 32'd1);
        exp_q.push_back(rec(0, 0, 5));
        step(5, 1'b0);
        exp_q.push_back(rec(0, 0, 6));
        step(6, 1'b0);
        exp_q.push_back(rec(1, 0, 2));
        step(0, 1'b1);
        drain("after_full");

        // reset with 5 records buffered and a packet open
        bus.out_ready = 1'b0;
        for (int i = 9; i <= 13; i++) step(i, 1'b0);
        check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        bus.id_in  = '0;
        bus.eop_in = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_perm", 32'(bus.perm_out), 32'd1);
        check_eq("mid_rst_err", 32'(bus.err_trailer_lost), 32'd0);
        exp_q.push_back(rec(0, 0, 4));
        step(4, 1'b0);
        exp_q.push_back(rec(1, 0, 1));
        step(0, 1'b1);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
